leddc_serial_tx: RTL

//  Host-side serial transmitter feeding the LED driver's DCK/DAI/DEN data port.
//  - Accepts 16-bit grayscale words over a valid/ready handshake.
//  - Shifts each word out LSB-first as a 16-cycle DEN-high burst.
//  - Sends one frame of WORDS_PER_FRAME words per frame_start, then pulses frame_done.

---
 rtl/leddc_serial_tx_if.sv | 19 +
 rtl/leddc_serial_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/leddc_serial_tx_if.sv
// leddc_serial_tx_if: valid/ready word stream feeding the serial transmitter.
// The host side drives word_in/word_valid; the transmitter answers word_ready.
interface leddc_serial_tx_if;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/leddc_serial_tx.sv
// leddc_serial_tx: LSB-first DCK/DAI/DEN word serialiser for the LED driver.
// Optional sticky underrun output is built when TX_UNDERRUN_EN is defined.
module leddc_serial_tx #(
  parameter int WORDS_PER_FRAME = 256,
  parameter int GAP_CYCLES      = 0
) (
  input  logic             DCK,
  input  logic             rst,
  input  logic             frame_start,
  leddc_serial_tx_if.slave tx,
  output logic             DAI,
  output logic             DEN,
  output logic             busy,
  output logic             frame_done
`ifdef TX_UNDERRUN_EN
  ,
  output logic             underrun
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(WORDS_PER_FRAME - 1);
  localparam logic [15:0] LAST_GAP  = 16'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

  state_t      state;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;
  logic [15:0] word_cnt;
  logic [15:0] gap_cnt;

  logic last_bit;
  logic last_word;
  logic accept;

  // Word boundary: the cycle carrying bit 15 of the current word.
  assign last_bit  = (state == SHIFT) && (bit_cnt == 4'd15);
  assign last_word = (word_cnt == LAST_WORD);

  // Ready while waiting in LOAD, or at a gapless boundary that has more words.
  assign tx.word_ready = (state == LOAD) ||
                         (last_bit && !HAS_GAP && !last_word);
  assign accept        = tx.word_ready && tx.word_valid;
  assign busy          = (state != IDLE);

  // Frame sequencer, shift register and registered DAI/DEN/frame_done.
  always_ff @(posedge DCK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      DAI        <= 1'b0;
      DEN        <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= 16'd0;
      bit_cnt    <= 4'd0;
      word_cnt   <= 16'd0;
      gap_cnt    <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          DAI <= 1'b0;
          DEN <= 1'b0;
          if (frame_start) begin
            word_cnt <= 16'd0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            DAI     <= tx.word_in[0];
            DEN     <= 1'b1;
            shreg   <= tx.word_in >> 1;
            bit_cnt <= 4'd0;
            state   <= SHIFT;
          end else begin
            DAI <= 1'b0;
            DEN <= 1'b0;
          end
        end
        SHIFT: begin
          DAI     <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            word_cnt <= word_cnt + 16'd1;
            if (last_word) begin
              DAI        <= 1'b0;
              DEN        <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else if (HAS_GAP) begin
              DAI     <= 1'b0;
              DEN     <= 1'b0;
              gap_cnt <= 16'd0;
              state   <= GAP;
            end else if (accept) begin
              DAI     <= tx.word_in[0];
              shreg   <= tx.word_in >> 1;
              bit_cnt <= 4'd0;
            end else begin
              DAI   <= 1'b0;
              DEN   <= 1'b0;
              state <= LOAD;
            end
          end
        end
        GAP: begin
          DAI <= 1'b0;
          DEN <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef TX_UNDERRUN_EN
  // Sticky mid-frame starvation flag; a new accepted frame clears it.
  always_ff @(posedge DCK or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if ((state == IDLE) && frame_start) begin
      underrun <= 1'b0;
    end else if (tx.word_ready && !tx.word_valid &&
                 busy && (word_cnt != 16'd0)) begin
      underrun <= 1'b1;
    end
  end
`endif

endmodule
